// File: rtl/iir_inv_pkg.sv
// Shared types and fixed-point helpers for the first-order IIR inverse filter.
// Helpers work on a 64-bit signed container; callers cast to their own widths.
package iir_inv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC_A = 3'd1,
        ST_MAC_B = 3'd2,
        ST_SCALE = 3'd3,
        ST_OUT   = 3'd4
    } iir_state_e;

    // Accumulator must hold the widest aligned term plus two guard bits.
    function automatic int acc_width(input int len_inter, input int len_coef,
                                     input int len_in, input int frac_in,
                                     input int frac_inter, input int frac_coef);
        int prod_w;
        int load_w;
        prod_w = len_inter + len_coef;
        load_w = len_in + frac_inter + frac_coef - frac_in;
        return ((prod_w > load_w) ? prod_w : load_w) + 2;
    endfunction

    function automatic logic signed [63:0] max_val(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] min_val(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Round half up: add half an output LSB, then arithmetic shift.
    function automatic logic signed [63:0] rnd_half_up(input logic signed [63:0] v,
                                                       input int unsigned sh);
        if (sh == 0) begin
            return v;
        end
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic out_of_range(input logic signed [63:0] v, input int unsigned w);
        return (v > max_val(w)) || (v < min_val(w));
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
        if (v > max_val(w)) begin
            return max_val(w);
        end
        if (v < min_val(w)) begin
            return min_val(w);
        end
        return v;
    endfunction

endpackage

// File: rtl/iir_inv_requant.sv
// Requantizes an INTER-format value to OUT format with round-half-up.
// IIR_INV_SAT_EN selects saturation; otherwise high bits are dropped (wrap).
module iir_inv_requant
    import iir_inv_pkg::*;
#(
    parameter int IN_W     = 24,
    parameter int IN_FRAC  = 18,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 14
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o,
    output logic                    ovf_o
);

    logic signed [63:0] rounded;

    always_comb begin
        rounded = rnd_half_up(64'(din_i), IN_FRAC - OUT_FRAC);
        ovf_o   = out_of_range(rounded, OUT_W);
`ifdef IIR_INV_SAT_EN
        dout_o  = OUT_W'(sat(rounded, OUT_W));
`else
        dout_o  = OUT_W'(rounded);
`endif
    end

endmodule

// File: rtl/iir_inverse_filter.sv
// Inverse of a first-order IIR section: x = g0*(y + a1*y_prev - b1*x_prev),
// computed with one shared multiplier over five FSM states.
module iir_inverse_filter
    import iir_inv_pkg::*;
#(
    parameter int WORD_LEN_IN     = 16,
    parameter int WORD_FRAC_IN    = 14,
    parameter int WORD_LEN_OUT    = 16,
    parameter int WORD_FRAC_OUT   = 14,
    parameter int WORD_LEN_COEF   = 16,
    parameter int WORD_FRAC_COEF  = 14,
    parameter int WORD_LEN_INTER  = 24,
    parameter int WORD_FRAC_INTER = 18
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [WORD_LEN_IN-1:0]   y_in,
    input  logic signed [WORD_LEN_COEF-1:0] a1,
    input  logic signed [WORD_LEN_COEF-1:0] b1,
    input  logic signed [WORD_LEN_COEF-1:0] g0,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [WORD_LEN_OUT-1:0]  x_out,
    output logic                            busy,
    output logic                            ovf
);

    localparam int ACC_W = acc_width(WORD_LEN_INTER, WORD_LEN_COEF, WORD_LEN_IN,
                                     WORD_FRAC_IN, WORD_FRAC_INTER, WORD_FRAC_COEF);
    localparam int SH_LOAD = WORD_FRAC_INTER + WORD_FRAC_COEF - WORD_FRAC_IN;
    localparam int SH_Y    = WORD_FRAC_INTER - WORD_FRAC_IN;

    iir_state_e                      state_q, state_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic signed [WORD_LEN_IN-1:0]   y_cur_q, y_cur_d, y_prev_q, y_prev_d;
    logic signed [WORD_LEN_INTER-1:0] x_prev_q, x_prev_d;
    logic signed [WORD_LEN_COEF-1:0] a1_q, a1_d, b1_q, b1_d, g0_q, g0_d;
    logic signed [WORD_LEN_OUT-1:0]  x_out_q, x_out_d;
    logic                            out_valid_q, out_valid_d, ovf_q, ovf_d;

    logic signed [63:0]               t_w, mul_a, mul_b, prod, xs_w;
    logic signed [WORD_LEN_INTER-1:0] x_scaled;
    logic signed [WORD_LEN_OUT-1:0]   rq_out;
    logic                             rq_ovf;

    assign in_ready  = (state_q == ST_IDLE) && reset;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign ovf       = ovf_q;

    // Every product lands at WORD_FRAC_INTER + WORD_FRAC_COEF fraction bits.
    always_comb begin
        t_w   = sat(rnd_half_up(64'(acc_q), WORD_FRAC_COEF), WORD_LEN_INTER);
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            ST_MAC_A: begin
                mul_a = 64'(a1_q);
                mul_b = 64'(y_prev_q) <<< SH_Y;
            end
            ST_MAC_B: begin
                mul_a = 64'(b1_q);
                mul_b = 64'(x_prev_q);
            end
            ST_SCALE: begin
                mul_a = 64'(g0_q);
                mul_b = t_w;
            end
            default: ;
        endcase
        prod     = mul_a * mul_b;
        xs_w     = sat(rnd_half_up(prod, WORD_FRAC_COEF), WORD_LEN_INTER);
        x_scaled = WORD_LEN_INTER'(xs_w);
    end

    iir_inv_requant #(
        .IN_W     (WORD_LEN_INTER),
        .IN_FRAC  (WORD_FRAC_INTER),
        .OUT_W    (WORD_LEN_OUT),
        .OUT_FRAC (WORD_FRAC_OUT)
    ) u_requant (
        .din_i  (x_scaled),
        .dout_o (rq_out),
        .ovf_o  (rq_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        y_cur_d     = y_cur_q;
        y_prev_d    = y_prev_q;
        x_prev_d    = x_prev_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        g0_d        = g0_q;
        x_out_d     = x_out_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    y_cur_d = y_in;
                    a1_d    = a1;
                    b1_d    = b1;
                    g0_d    = g0;
                    acc_d   = ACC_W'(64'(y_in) <<< SH_LOAD);
                    state_d = ST_MAC_A;
                end
            end
            ST_MAC_A: begin
                acc_d   = acc_q + ACC_W'(prod);
                state_d = ST_MAC_B;
            end
            ST_MAC_B: begin
                acc_d   = acc_q - ACC_W'(prod);
                state_d = ST_SCALE;
            end
            ST_SCALE: begin
                x_prev_d    = x_scaled;
                y_prev_d    = y_cur_q;
                x_out_d     = rq_out;
                out_valid_d = 1'b1;
                ovf_d       = ovf_q | rq_ovf;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            y_cur_q     <= '0;
            y_prev_q    <= '0;
            x_prev_q    <= '0;
            a1_q        <= '0;
            b1_q        <= '0;
            g0_q        <= '0;
            x_out_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            y_cur_q     <= y_cur_d;
            y_prev_q    <= y_prev_d;
            x_prev_q    <= x_prev_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            g0_q        <= g0_d;
            x_out_q     <= x_out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_iir_inverse_filter.sv
// Directed bench for iir_inverse_filter: Q2.14 vectors with hand-computed results.
// Overflow expectation follows IIR_INV_SAT_EN.
module tb_iir_inverse_filter;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] y_in = '0;
    logic signed [15:0] a1 = '0;
    logic signed [15:0] b1 = '0;
    logic signed [15:0] g0 = 16'sd16384;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] x_out;
    logic               busy;
    logic               ovf;

    int checks = 0;
    int failures = 0;

`ifdef IIR_INV_SAT_EN
    localparam int OVF_X_EXP = 32767;
`else
    localparam int OVF_X_EXP = -3278;
`endif

    always #5 clk = ~clk;

    iir_inverse_filter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .a1        (a1),
        .b1        (b1),
        .g0        (g0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .busy      (busy),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Offer one sample, wait (bounded) for the result, check it, then handshake.
    task automatic send(input logic signed [15:0] y, input int exp, input string tag);
        int n;
        in_valid = 1'b1;
        y_in     = y;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk(tag, 32'(x_out), exp);
        tick();
    endtask

    initial begin
        #1;
        chk("rst_x_out", 32'(x_out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("idle_in_ready", 32'(in_ready), 1);

        // Pass-through with latency: accept at E0, out_valid after E3.
        a1 = 16'sd0; b1 = 16'sd0; g0 = 16'sd16384;
        in_valid = 1'b1; y_in = 16'sd8192;
        tick();
        in_valid = 1'b0;
        chk("lat_e0_busy", 32'(busy), 1);
        chk("lat_e0_in_ready", 32'(in_ready), 0);
        chk("lat_e0_valid", 32'(out_valid), 0);
        tick();
        chk("lat_e1_valid", 32'(out_valid), 0);
        tick();
        chk("lat_e2_valid", 32'(out_valid), 0);
        tick();
        chk("lat_e3_valid", 32'(out_valid), 1);
        chk("pass_x", 32'(x_out), 8192);
        tick();
        chk("pass_hs_valid", 32'(out_valid), 0);
        chk("pass_hs_busy", 32'(busy), 0);

        // Feed-forward term: impulse recovered.
        do_reset();
        a1 = -16'sd8192; b1 = 16'sd0; g0 = 16'sd16384;
        send(16'sd16384, 16384, "ff0");
        send(16'sd8192, 0, "ff1");
        send(16'sd4096, 0, "ff2");

        // Feedback term.
        do_reset();
        a1 = 16'sd0; b1 = 16'sd8192; g0 = 16'sd16384;
        send(16'sd16384, 16384, "fb0");
        send(16'sd0, -8192, "fb1");
        send(16'sd0, 4096, "fb2");

        // Backpressure; g0 changed mid-sample only affects the next sample.
        do_reset();
        a1 = 16'sd0; b1 = 16'sd0; g0 = 16'sd16384;
        out_ready = 1'b0;
        in_valid = 1'b1; y_in = 16'sd4096;
        tick();
        y_in = 16'sd12288;
        g0 = 16'sd8192;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_x", 32'(x_out), 4096);
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 32'(out_valid), 0);
        chk("bp_hs_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_busy", 32'(busy), 1);
        repeat (3) tick();
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_x", 32'(x_out), 6144);
        tick();
        repeat (3) tick();
        chk("bp_no_extra", 32'(out_valid), 0);

        // Output overflow: 31130 * 32767 / 2^14 rounds to 62258.
        do_reset();
        chk("ovf_pre", 32'(ovf), 0);
        a1 = 16'sd0; b1 = 16'sd0; g0 = 16'sd32767;
        send(16'sd31130, OVF_X_EXP, "ovf_x");
        chk("ovf_flag", 32'(ovf), 1);
        send(16'sd0, 0, "ovf_zero");
        chk("ovf_sticky", 32'(ovf), 1);

        // Reset in MAC_B drops the sample and clears history.
        a1 = -16'sd8192; b1 = 16'sd0; g0 = 16'sd16384;
        send(16'sd16384, 16384, "mr_hist");
        in_valid = 1'b1; y_in = 16'sd4096;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_ovf", 32'(ovf), 0);
        chk("mr_in_ready", 32'(in_ready), 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("mr_dropped", 32'(out_valid), 0);
        send(16'sd8192, 8192, "mr_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
